sccb_slave: RTL and testbench

//  SCCB target (OV7670-style camera side). Decodes 3-phase writes, 2-phase writes and
//  2-phase reads driven on sio_c/sio_d by an SCCB master. Exposes a one-cycle

---
 rtl/sccb_slave.sv | 212 +++++++++++++++++++++
 tb/tb_sccb_slave.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_slave.sv
// SCCB target: decodes 3-phase writes, 2-phase writes and 2-phase reads into register strobes.
// Define SCCB_SLAVE_ACK_EN to have the block pull the 9th bit low on matched write phases.
module sccb_slave #(
  parameter logic [7:0] DEV_ID   = 8'h42,
  parameter int          SYNC_LEN = 2
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       sio_c,
  input  logic       sio_d_in,
  output logic       sio_d_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       xfer_done
);

`ifdef SCCB_SLAVE_ACK_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RD_NA, IGNORE
  } state_e;

  // Sync flops reset high so an idle bus never looks like an edge after reset.
  logic [SYNC_LEN-1:0] scl_sync_q, sda_sync_q;
  logic                scl_prev_q, sda_prev_q;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_LEN-2:0], sio_c};
      sda_sync_q <= {sda_sync_q[SYNC_LEN-2:0], sio_d_in};
      scl_prev_q <= scl_sync_q[SYNC_LEN-1];
      sda_prev_q <= sda_sync_q[SYNC_LEN-1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, scl_stable_hi, start_c, stop_c;

  assign scl_s    = scl_sync_q[SYNC_LEN-1];
  assign sda_s    = sda_sync_q[SYNC_LEN-1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  // SDA moving in the same cycle as SCL is data, not a bus condition.
  assign scl_stable_hi = scl_s & scl_prev_q;
  assign start_c  = scl_stable_hi & ~sda_s & sda_prev_q;
  assign stop_c   = scl_stable_hi & sda_s & ~sda_prev_q;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rose_q, rose_d;
  logic        rd_q, rd_d;
  logic        match_q, match_d;
  logic        oe_q, oe_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic        done_q, done_d;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      rose_q    <= 1'b0;
      rd_q      <= 1'b0;
      match_q   <= 1'b0;
      oe_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rose_q    <= rose_d;
      rd_q      <= rd_d;
      match_q   <= match_d;
      oe_q      <= oe_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rose_d    = rose_q;
    rd_d      = rd_q;
    match_d   = match_q;
    oe_d      = oe_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    done_d    = 1'b0;

    if (stop_c) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      rose_d    = 1'b0;
      rd_d      = 1'b0;
      match_d   = 1'b0;
      oe_d      = 1'b0;
      done_d    = match_q;
    end else if (start_c) begin
      state_d   = DEV;
      bit_cnt_d = 4'd0;
      rose_d    = 1'b0;
      rd_d      = 1'b0;
      match_d   = 1'b0;
      oe_d      = 1'b0;
    end else if (scl_rise) begin
      rose_d = 1'b1;
      if (state_q == DEV || state_q == ADDR || state_q == WDATA) begin
        shift_d = {shift_q[6:0], sda_s};
        if (bit_cnt_q == 4'd7 && state_q == ADDR) begin
          addr_d = shift_d;
        end
        if (bit_cnt_q == 4'd7 && state_q == WDATA) begin
          wdata_d = shift_d;
          wr_en_d = 1'b1;
        end
      end
    // The first SCL fall after START has no sampled bit behind it, hence rose_q.
    end else if (scl_fall && rose_q) begin
      rose_d = 1'b0;
      case (state_q)
        DEV: begin
          if (bit_cnt_q != 4'd7) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (shift_q[7:1] != DEV_ID[7:1]) begin
            state_d = IGNORE;
          end else begin
            state_d   = DEV_ACK;
            bit_cnt_d = 4'd8;
            match_d   = 1'b1;
            rd_d      = shift_q[0];
            rd_en_d   = shift_q[0];
            oe_d      = ACK_EN;
          end
        end
        DEV_ACK: begin
          bit_cnt_d = 4'd0;
          if (rd_q) begin
            state_d = RDATA;
            shift_d = reg_rdata;
            oe_d    = ~reg_rdata[7];
          end else begin
            state_d = ADDR;
            oe_d    = 1'b0;
          end
        end
        ADDR, WDATA: begin
          if (bit_cnt_q == 4'd7) begin
            state_d   = (state_q == ADDR) ? ADDR_ACK : WDATA_ACK;
            bit_cnt_d = 4'd8;
            oe_d      = ACK_EN;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        ADDR_ACK, WDATA_ACK: begin
          state_d   = WDATA;
          bit_cnt_d = 4'd0;
          oe_d      = 1'b0;
        end
        RDATA: begin
          if (bit_cnt_q == 4'd7) begin
            state_d   = RD_NA;
            bit_cnt_d = 4'd8;
            oe_d      = 1'b0;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            oe_d      = ~shift_q[6];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sio_d_oe  = oe_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr_en = wr_en_q;
  assign reg_rd_en = rd_en_q;
  assign busy      = (state_q != IDLE);
  assign xfer_done = done_q;

endmodule

// File: tb/tb_sccb_slave.sv
// Bench for sccb_slave: a bit-banged SCCB master drives a vector table plus abort and reset sequences.
`timescale 1ns/1ps
module tb_sccb_slave;

  localparam int SYNC_LEN = 2;
  localparam int Q        = 16;
`ifdef SCCB_SLAVE_ACK_EN
  localparam bit ACK_ON = 1'b1;
`else
  localparam bit ACK_ON = 1'b0;
`endif

  typedef enum int {K_W3, K_W2R, K_BAD, K_RS} kind_e;
  typedef struct {
    kind_e      kind;
    logic [7:0] id;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] rdata;
    int         exp_wr;
    int         exp_rd;
    int         exp_done;
    logic [7:0] exp_addr;
  } vec_t;

  logic       sclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sio_d_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wr_en, reg_rd_en, busy, xfer_done;

  logic [7:0]  mem [256];
  logic [15:0] wr_q [$];
  logic [7:0]  rd_q [$];
  int n_vec = 0, n_err = 0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, oe_cnt = 0;
  vec_t vecs [6];

  // Open-drain bus: either side can pull low.
  assign sda_line = sda_m & ~sio_d_oe;

  always #10 sclk = ~sclk;

  sccb_slave #(.DEV_ID(8'h42), .SYNC_LEN(SYNC_LEN)) dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .sio_c     (scl_m),
    .sio_d_in  (sda_line),
    .sio_d_oe  (sio_d_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr_en (reg_wr_en),
    .reg_rd_en (reg_rd_en),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .xfer_done (xfer_done)
  );

  task automatic chk(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
    end
  endtask

  // Register-file side: answers reads, scoreboards writes, counts strobes.
  always @(negedge sclk) begin
    if (sio_d_oe) oe_cnt++;
    if (xfer_done) done_cnt++;
    if (reg_rd_en) begin
      rd_cnt++;
      reg_rdata = mem[reg_addr];
    end
    if (reg_wr_en) begin
      wr_cnt++;
      if (wr_q.size() == 0) begin
        chk("unexpected_wr_strobe", {reg_addr, reg_wdata}, 32'hFFFF_FFFF);
      end else begin
        chk("wr_strobe_addr_data", {reg_addr, reg_wdata}, wr_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; cyc(Q);
    scl_m = 1'b1; cyc(Q);
    sda_m = 1'b0; cyc(Q);
    scl_m = 1'b0; cyc(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; cyc(Q);
    scl_m = 1'b1; cyc(Q);
    sda_m = 1'b1; cyc(Q);
  endtask

  task automatic bus_bit(input logic b, output logic r);
    sda_m = b;    cyc(Q);
    scl_m = 1'b1; cyc(Q);
    r = sda_line; cyc(Q);
    scl_m = 1'b0; cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic exp_ack, input string nm);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(v[i], r);
    bus_bit(1'b1, r);
    chk(nm, r, exp_ack);
  endtask

  task automatic recv_byte(output logic [7:0] v);
    logic r;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, r);
      v = {v[6:0], r};
    end
    sda_m = 1'b1; cyc(Q);
    scl_m = 1'b1; cyc(Q);
    chk("rd_9th_bit_oe", sio_d_oe, 0);
    cyc(Q);
    scl_m = 1'b0; cyc(Q);
  endtask

  task automatic read_phase(input vec_t v, input logic exp_ack);
    logic [7:0] rb;
    rd_q.push_back(v.rdata);
    send_byte(v.id | 8'h01, exp_ack, "read_id_ack");
    recv_byte(rb);
    chk("read_byte", rb, rd_q.pop_front());
    bus_stop();
  endtask

  task automatic do_vec(input vec_t v, input int idx);
    int   wr0, rd0, dn0, oe0;
    logic ack_exp;
    wr0 = wr_cnt; rd0 = rd_cnt; dn0 = done_cnt; oe0 = oe_cnt;
    ack_exp = (v.kind != K_BAD) ? ~ACK_ON : 1'b1;
    bus_start();
    chk("busy_after_start", busy, 1);
    send_byte(v.id, ack_exp, "id_ack");
    send_byte(v.addr, ack_exp, "addr_ack");
    case (v.kind)
      K_W3, K_BAD: begin
        if (v.kind == K_W3) wr_q.push_back({v.addr, v.data});
        send_byte(v.data, ack_exp, "data_ack");
        bus_stop();
      end
      K_W2R: begin
        bus_stop();
        mem[v.addr] = v.rdata;
        bus_start();
        read_phase(v, ack_exp);
      end
      default: begin
        mem[v.addr] = v.rdata;
        bus_start();
        read_phase(v, ack_exp);
      end
    endcase
    cyc(4);
    chk("wr_strobe_count", wr_cnt - wr0, v.exp_wr);
    chk("rd_strobe_count", rd_cnt - rd0, v.exp_rd);
    chk("xfer_done_count", done_cnt - dn0, v.exp_done);
    chk("reg_addr_after", reg_addr, v.exp_addr);
    chk("busy_after_stop", busy, 0);
    chk("wr_queue_drained", wr_q.size(), 0);
    if (v.kind == K_W3 || v.kind == K_BAD)
      chk("oe_during_write", (oe_cnt != oe0) ? 1 : 0, (v.kind == K_W3) ? int'(ACK_ON) : 0);
    $display("vec %0d: kind=%0d id=%02h addr=%02h data=%02h rdata=%02h reg_addr=%02h",
             idx, v.kind, v.id, v.addr, v.data, v.rdata, reg_addr);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_oe"}, sio_d_oe, 0);
    chk({tag, "_reg_addr"}, reg_addr, 0);
    chk({tag, "_reg_wdata"}, reg_wdata, 0);
    chk({tag, "_wr_en"}, reg_wr_en, 0);
    chk({tag, "_rd_en"}, reg_rd_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_xfer_done"}, xfer_done, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int   wr0, dn0, lat;
    logic r;
    vec_t rec;
    vecs[0] = '{K_W3,  8'h42, 8'h12, 8'h80, 8'h00, 1, 0, 1, 8'h12};
    vecs[1] = '{K_W2R, 8'h42, 8'h0A, 8'h00, 8'h76, 0, 1, 2, 8'h0A};
    vecs[2] = '{K_BAD, 8'h60, 8'h12, 8'h55, 8'h00, 0, 0, 0, 8'h0A};
    vecs[3] = '{K_RS,  8'h42, 8'h20, 8'h00, 8'hC3, 0, 1, 1, 8'h20};
    vecs[4] = '{K_W3,  8'h42, 8'h5A, 8'h3C, 8'h00, 1, 0, 1, 8'h5A};
    vecs[5] = '{K_BAD, 8'h40, 8'h99, 8'h11, 8'h00, 0, 0, 0, 8'h5A};
    rec     = '{K_W3,  8'h42, 8'h12, 8'h80, 8'h00, 1, 0, 1, 8'h12};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    cyc(3);
    chk_reset_outs("por");
    rst_n = 1'b1;
    cyc(5);

    for (int i = 0; i < 6; i++) do_vec(vecs[i], i);

    // STOP after half a data byte: byte discarded, busy drop timed from the SDA rise.
    wr0 = wr_cnt; dn0 = done_cnt;
    bus_start();
    send_byte(8'h42, ~ACK_ON, "abort_id_ack");
    send_byte(8'h33, ~ACK_ON, "abort_addr_ack");
    bus_bit(1'b1, r); bus_bit(1'b0, r); bus_bit(1'b1, r); bus_bit(1'b0, r);
    sda_m = 1'b0; cyc(Q);
    scl_m = 1'b1; cyc(Q);
    sda_m = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge sclk); #1;
      if (!busy) begin
        lat = k;
        break;
      end
    end
    chk("busy_fall_latency", lat, SYNC_LEN + 1);
    cyc(Q);
    chk("abort_wr_count", wr_cnt - wr0, 0);
    chk("abort_reg_addr", reg_addr, 8'h33);
    chk("abort_xfer_done", done_cnt - dn0, 1);
    $display("abort: reg_addr=%02h busy latency=%0d", reg_addr, lat);

    // Asynchronous reset in the middle of a data byte.
    bus_start();
    send_byte(8'h42, ~ACK_ON, "rst_id_ack");
    send_byte(8'h77, ~ACK_ON, "rst_addr_ack");
    bus_bit(1'b1, r); bus_bit(1'b1, r); bus_bit(1'b1, r); bus_bit(1'b0, r);
    chk("busy_before_reset", busy, 1);
    @(posedge sclk); #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    scl_m = 1'b1; sda_m = 1'b1;
    cyc(5);
    rst_n = 1'b1;
    cyc(5);
    $display("reset: outputs cleared mid-transfer, reg_addr=%02h", reg_addr);
    do_vec(rec, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
